scratchpad_dram_bridge: RTL and testbench

- Sits between the scratchpad bank and the DRAM/memory-bus port.
- Pops scratchpad requests from the bank's dramFIFO.
- Executes each request as a BURST-beat transfer on a word-wide memory handshake.
- Load requests: reassembles the read beats into a full row and pushes it into the bank's wFIFO. Store requests: slices the row into write beats.

---
 rtl/sp_types_pkg.sv | 47 ++++
 rtl/scratchpad_dram_bridge.sv | 119 +++++++++++
 tb/tb_scratchpad_dram_bridge.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_types_pkg.sv
// Shared types for the scratchpad bank and its DRAM bridge: beat/row geometry,
// request and write-row layouts, and the bridge FSM state encoding.
package sp_types_pkg;

    localparam int WORD_W         = 16;
    localparam int BURST          = 4;
    localparam int ROW_W          = WORD_W * BURST;
    localparam int TAG_W          = 4;
    localparam int ADDR_W         = 32;
    localparam int BEAT_W         = $clog2(BURST);
    localparam int BYTES_PER_BEAT = WORD_W / 8;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } dram_op_t;

    typedef struct packed {
        dram_op_t           op;
        logic [TAG_W-1:0]   tag;
        logic [ADDR_W-1:0]  addr;
        logic [ROW_W-1:0]   data;
    } dram_req_t;

    typedef dram_req_t dramFIFO_t;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [ROW_W-1:0]   data;
    } wrow_t;

    typedef wrow_t wFIFO_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        PUSH  = 2'd2,
        STORE = 2'd3
    } bridge_state_t;

    // Byte address of a given beat within a row; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [BEAT_W-1:0] beat);
        return base + (ADDR_W'(beat) * ADDR_W'(BYTES_PER_BEAT));
    endfunction

endpackage

// File: rtl/scratchpad_dram_bridge.sv
// Bridge between the scratchpad bank request FIFO and a word-wide memory port.
// Each request moves one full row as BURST beats; loads are reassembled into a
// row and pushed to the bank write FIFO, stores are sliced into write beats.
module scratchpad_dram_bridge
    import sp_types_pkg::*;
(
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          dramFIFO_empty,
    input  logic [1+TAG_W+ADDR_W+ROW_W-1:0] dramFIFO_rdata,
    output logic                          dramFIFO_REN,
    input  logic                          wFIFO_full,
    output logic                          wFIFO_WEN,
    output logic [TAG_W+ROW_W-1:0]        wFIFO_wdata,
    output logic                          mem_REN,
    output logic                          mem_WEN,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [WORD_W-1:0]             mem_store,
    input  logic [WORD_W-1:0]             mem_load,
    input  logic                          mem_ready,
    output logic                          busy
);

    bridge_state_t           state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [ROW_W-1:0]        row_q, row_d;

    dram_req_t               req;
    wrow_t                   wrow;
    logic                    last_beat;
    logic [$clog2(ROW_W)-1:0] slice_off;

    assign req       = dram_req_t'(dramFIFO_rdata);
    assign last_beat = (beat_q == BEAT_W'(BURST - 1));
    // Bit offset of the current beat inside the row buffer (beat 0 = LSBs).
    assign slice_off = {beat_q, {$clog2(WORD_W){1'b0}}};

    // Next-state, beat counter and row-buffer update.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tag_d   = tag_q;
        addr_d  = addr_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (!dramFIFO_empty) begin
                    tag_d   = req.tag;
                    addr_d  = req.addr;
                    row_d   = req.data;
                    beat_d  = '0;
                    state_d = (req.op == OP_STORE) ? STORE : LOAD;
                end
            end
            LOAD: begin
                if (mem_ready) begin
                    row_d[slice_off +: WORD_W] = mem_load;
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = PUSH;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                    end
                end
            end
            PUSH: begin
                if (!wFIFO_full) begin
                    state_d = IDLE;
                end
            end
            STORE: begin
                if (mem_ready) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any transfer and discards the row.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            beat_q  <= '0;
            tag_q   <= '0;
            addr_q  <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tag_q   <= tag_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
        end
    end

    // Strobes are suppressed while reset is held so nothing is popped, pushed
    // or issued on the edge that aborts the transfer.
    assign dramFIFO_REN = !RST && (state_q == IDLE) && !dramFIFO_empty;
    assign mem_REN      = !RST && (state_q == LOAD);
    assign mem_WEN      = !RST && (state_q == STORE);
    assign wFIFO_WEN    = !RST && (state_q == PUSH) && !wFIFO_full;
    assign busy         = (state_q != IDLE);

    assign wrow.tag    = tag_q;
    assign wrow.data   = row_q;
    assign wFIFO_wdata = wrow;

    assign mem_addr  = (state_q == LOAD || state_q == STORE) ? beat_addr(addr_q, beat_q) : '0;
    assign mem_store = (state_q == STORE) ? row_q[slice_off +: WORD_W] : '0;

endmodule

// File: tb/tb_scratchpad_dram_bridge.sv
// Directed and randomized checks of the scratchpad DRAM bridge against a
// transaction-level model: a request queue, a reference word memory and
// expected queues of read addresses, write beats and pushed rows.
module tb_scratchpad_dram_bridge;
    import sp_types_pkg::*;

    logic                            CLK = 1'b0;
    logic                            RST;
    logic                            dramFIFO_empty;
    logic [1+TAG_W+ADDR_W+ROW_W-1:0] dramFIFO_rdata;
    logic                            dramFIFO_REN;
    logic                            wFIFO_full;
    logic                            wFIFO_WEN;
    logic [TAG_W+ROW_W-1:0]          wFIFO_wdata;
    logic                            mem_REN;
    logic                            mem_WEN;
    logic [ADDR_W-1:0]               mem_addr;
    logic [WORD_W-1:0]               mem_store;
    logic [WORD_W-1:0]               mem_load;
    logic                            mem_ready;
    logic                            busy;

    always #5 CLK = ~CLK;

    scratchpad_dram_bridge dut (
        .CLK(CLK), .RST(RST),
        .dramFIFO_empty(dramFIFO_empty), .dramFIFO_rdata(dramFIFO_rdata), .dramFIFO_REN(dramFIFO_REN),
        .wFIFO_full(wFIFO_full), .wFIFO_WEN(wFIFO_WEN), .wFIFO_wdata(wFIFO_wdata),
        .mem_REN(mem_REN), .mem_WEN(mem_WEN), .mem_addr(mem_addr), .mem_store(mem_store),
        .mem_load(mem_load), .mem_ready(mem_ready), .busy(busy)
    );

    // Memory device seen by the DUT, and the model's own copy of memory.
    logic [15:0] mem_arr [0:255];
    logic [15:0] ref_mem [0:255];
    assign mem_load = mem_REN ? mem_arr[mem_addr[8:1]] : 16'h0;

    dram_req_t   req_q[$];
    logic [67:0] obs_push[$], exp_push[$];
    logic [31:0] obs_rd[$],   exp_rd[$];
    logic [47:0] obs_wr[$],   exp_wr[$];
    int          ren_cyc[$],  push_cyc[$];

    int   checks = 0, failures = 0, cyc = 0;
    int   rdy_mode = 0;
    logic rdy_tog = 1'b1;
    logic full_fix = 1'b0;
    bit   full_rand = 1'b0;
    logic pend = 1'b0, pend_w = 1'b0;
    logic [31:0] pend_addr;
    logic [15:0] pend_data;
    logic snap_wen, snap_ren;
    logic [67:0] snap_wdata;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, sample, record events.
    task automatic tick();
        logic ren;
        dramFIFO_empty = (req_q.size() == 0);
        dramFIFO_rdata = dramFIFO_empty ? '0 : req_q[0];
        case (rdy_mode)
            0: mem_ready = 1'b1;
            1: begin mem_ready = rdy_tog; rdy_tog = !rdy_tog; end
            default: mem_ready = ($urandom_range(0, 3) != 0);
        endcase
        wFIFO_full = full_rand ? ($urandom_range(0, 2) == 0) : full_fix;
        #1;
        if (pend && !RST) begin
            chk("hold_addr", mem_addr, pend_addr);
            if (pend_w) chk("hold_data", mem_store, pend_data);
        end
        chk("rd_wr_excl", mem_REN & mem_WEN, 0);
        chk("wen_when_full", wFIFO_WEN & wFIFO_full, 0);
        chk("ren_when_empty", dramFIFO_REN & dramFIFO_empty, 0);
        if (dramFIFO_REN) ren_cyc.push_back(cyc);
        if (wFIFO_WEN) begin obs_push.push_back(wFIFO_wdata); push_cyc.push_back(cyc); end
        if (mem_REN && mem_ready) obs_rd.push_back(mem_addr);
        if (mem_WEN && mem_ready) begin
            obs_wr.push_back({mem_addr, mem_store});
            mem_arr[mem_addr[8:1]] = mem_store;
        end
        pend      = !RST && (mem_REN || mem_WEN) && !mem_ready;
        pend_addr = mem_addr;
        pend_data = mem_store;
        pend_w    = mem_WEN;
        snap_wen   = wFIFO_WEN;
        snap_ren   = dramFIFO_REN;
        snap_wdata = wFIFO_wdata;
        ren = dramFIFO_REN;
        @(posedge CLK);
        if (ren) void'(req_q.pop_front());
        @(negedge CLK);
        cyc++;
    endtask

    // Model: queue a request and derive the memory traffic it must produce.
    task automatic add_req(input logic op, input logic [3:0] tag, input logic [31:0] addr,
                           input logic [63:0] data);
        dram_req_t   r;
        logic [63:0] row;
        logic [31:0] a;
        r.op = dram_op_t'(op); r.tag = tag; r.addr = addr; r.data = data;
        req_q.push_back(r);
        row = '0;
        for (int i = 0; i < 4; i++) begin
            a = addr + 32'(2 * i);
            if (!op) begin
                exp_rd.push_back(a);
                row[16*i +: 16] = ref_mem[a[8:1]];
            end else begin
                exp_wr.push_back({a, data[16*i +: 16]});
                ref_mem[a[8:1]] = data[16*i +: 16];
            end
        end
        if (!op) exp_push.push_back({tag, row});
    endtask

    task automatic run_idle(input int bound);
        int n;
        n = 1;
        tick();
        while ((req_q.size() != 0 || busy) && n < bound) begin
            tick();
            n++;
        end
        chk("run_finished", {req_q.size() != 0, busy}, 0);
    endtask

    task automatic compare(input string name);
        chk({name, "_nrd"}, obs_rd.size(), exp_rd.size());
        for (int i = 0; i < obs_rd.size() && i < exp_rd.size(); i++)
            chk($sformatf("%s_rd%0d", name, i), obs_rd[i], exp_rd[i]);
        chk({name, "_nwr"}, obs_wr.size(), exp_wr.size());
        for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
            chk($sformatf("%s_wr%0d", name, i), obs_wr[i], exp_wr[i]);
        chk({name, "_npush"}, obs_push.size(), exp_push.size());
        for (int i = 0; i < obs_push.size() && i < exp_push.size(); i++)
            chk($sformatf("%s_push%0d", name, i), obs_push[i], exp_push[i]);
        obs_rd.delete(); exp_rd.delete(); obs_wr.delete(); exp_wr.delete();
        obs_push.delete(); exp_push.delete(); ren_cyc.delete(); push_cyc.delete();
    endtask

    task automatic check_zero(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_ren"}, dramFIFO_REN, 0);
        chk({name, "_wen"}, wFIFO_WEN, 0);
        chk({name, "_wdata"}, wFIFO_wdata, 0);
        chk({name, "_mren"}, mem_REN, 0);
        chk({name, "_mwen"}, mem_WEN, 0);
        chk({name, "_maddr"}, mem_addr, 0);
        chk({name, "_mstore"}, mem_store, 0);
    endtask

    initial begin
        logic [15:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            mem_arr[i] = v;
            ref_mem[i] = v;
        end
        RST = 1'b1; mem_ready = 1'b0; wFIFO_full = 1'b0;
        dramFIFO_empty = 1'b1; dramFIFO_rdata = '0;
        @(negedge CLK);
        tick(); tick();
        RST = 1'b0;
        #1;
        check_zero("reset");

        // Load with ready high: fixed data, latency REN to WEN.
        for (int i = 0; i < 4; i++) begin
            mem_arr[8'h80 + i] = 16'h1111 * 16'(i + 1);
            ref_mem[8'h80 + i] = 16'h1111 * 16'(i + 1);
        end
        add_req(1'b0, 4'd3, 32'h100, 64'($urandom));
        run_idle(50);
        if (obs_push.size() > 0) chk("t1_row", obs_push[0], {4'd3, 64'h4444_3333_2222_1111});
        if (push_cyc.size() > 0 && ren_cyc.size() > 0) chk("t1_latency", push_cyc[0] - ren_cyc[0], 5);
        compare("t1");

        // Store with ready toggling: beats held until accepted.
        rdy_mode = 1; rdy_tog = 1'b1;
        add_req(1'b1, 4'd0, 32'h200, 64'hDDDD_CCCC_BBBB_AAAA);
        run_idle(50);
        chk("t2_ren_count", ren_cyc.size(), 1);
        if (obs_wr.size() > 3) begin
            chk("t2_first", obs_wr[0], {32'h200, 16'hAAAA});
            chk("t2_last", obs_wr[3], {32'h206, 16'hDDDD});
        end
        compare("t2");

        // Backpressure: write FIFO full for five cycles during PUSH.
        rdy_mode = 0; full_fix = 1'b1;
        add_req(1'b0, 4'd5, 32'h0000_0040, '0);
        add_req(1'b0, 4'd6, 32'h0000_0080, '0);
        for (int k = 0; k < 5; k++) tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("t3_wen_full%0d", k), snap_wen, 0);
            chk($sformatf("t3_ren_full%0d", k), snap_ren, 0);
            chk($sformatf("t3_wdata%0d", k), snap_wdata, exp_push[0]);
        end
        full_fix = 1'b0;
        tick();
        chk("t3_wen_release", snap_wen, 1);
        run_idle(50);
        if (ren_cyc.size() > 1) chk("t3_ren_gap", ren_cyc[1] - ren_cyc[0], 11);
        compare("t3");

        // Back-to-back loads issue every BURST+2 cycles.
        for (int k = 0; k < 3; k++) add_req(1'b0, 4'($urandom), $urandom & ~32'h1, '0);
        run_idle(100);
        chk("t4_nren", ren_cyc.size(), 3);
        if (ren_cyc.size() > 2) begin
            chk("t4_gap0", ren_cyc[1] - ren_cyc[0], 6);
            chk("t4_gap1", ren_cyc[2] - ren_cyc[1], 6);
        end
        compare("t4");

        // Reset after beat 2 of a load aborts it.
        add_req(1'b0, 4'd9, 32'h0000_0300, '0);
        for (int k = 0; k < 4; k++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        check_zero("t5_after_rst");
        chk("t5_no_push", obs_push.size(), 0);
        obs_rd.delete(); exp_rd.delete(); obs_wr.delete(); exp_wr.delete();
        obs_push.delete(); exp_push.delete(); ren_cyc.delete(); push_cyc.delete();
        add_req(1'b0, 4'd10, 32'h0000_0310, '0);
        run_idle(50);
        if (obs_rd.size() > 0) chk("t5_beat0", obs_rd[0], 32'h0000_0310);
        compare("t5");

        // Address wrap-around across 2^32.
        add_req(1'b0, 4'd1, 32'hFFFF_FFFC, '0);
        run_idle(50);
        if (obs_rd.size() > 3) begin
            chk("t6_wrap2", obs_rd[2], 32'h0000_0000);
            chk("t6_wrap3", obs_rd[3], 32'h0000_0002);
        end
        compare("t6");

        // Random mix with random memory stalls and write-FIFO backpressure.
        rdy_mode = 2; full_rand = 1'b1;
        for (int k = 0; k < 20; k++)
            add_req(1'($urandom), 4'($urandom), $urandom & ~32'h1, {$urandom, $urandom});
        run_idle(3000);
        compare("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
